// File: rtl/blink_multi.sv
// Multi-channel LED blinker: per-channel OFF/ON/BLINK/PULSE on a shared tick.
// Define BLINK_SYNC_EN to add sync_i, which realigns every BLINK channel.
module blink_multi #(
    parameter int CLK_FREQ    = 25_000_000,
    parameter int TICK_HZ     = 1000,
    parameter int CHANNELS    = 8,
    parameter int TW          = 12,
    parameter int ON_DEFAULT  = 2000,
    parameter int OFF_DEFAULT = 500
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [4:0]          cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [TW-1:0]       cfg_on,
    input  logic [TW-1:0]       cfg_off,
`ifdef BLINK_SYNC_EN
    input  logic                sync_i,
`endif
    output logic [CHANNELS-1:0] leds,
    output logic [CHANNELS-1:0] pulse_busy
);

    localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_PULSE = 2'b11
    } mode_t;

    logic [PW-1:0]       r_pre;
    logic [PW-1:0]       w_pre;
    logic                w_tick;

    mode_t               r_mode  [CHANNELS];
    logic [TW-1:0]       r_on    [CHANNELS];
    logic [TW-1:0]       r_off   [CHANNELS];
    logic [TW-1:0]       r_cnt   [CHANNELS];
    logic [CHANNELS-1:0] r_phase;
    logic [CHANNELS-1:0] r_leds;
    logic [CHANNELS-1:0] r_busy;

    mode_t               w_mode  [CHANNELS];
    logic [TW-1:0]       w_on    [CHANNELS];
    logic [TW-1:0]       w_off   [CHANNELS];
    logic [TW-1:0]       w_cnt   [CHANNELS];
    logic [CHANNELS-1:0] w_phase;
    logic [CHANNELS-1:0] w_leds;
    logic [CHANNELS-1:0] w_busy;
    logic [CHANNELS-1:0] w_hit;

    // Last count value of a phase; a zero time behaves as one tick.
    function automatic logic [TW-1:0] f_last(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    assign w_tick = (r_pre == PW'(TICK_DIV - 1));

    always_comb begin
        w_pre = w_tick ? '0 : r_pre + 1'b1;
`ifdef BLINK_SYNC_EN
        if (sync_i) begin
            w_pre = '0;
        end
`endif
    end

    // Priority per channel: write, then sync, then tick.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_hit[i]   = cfg_we && (cfg_ch == 5'(i));
            w_mode[i]  = r_mode[i];
            w_on[i]    = r_on[i];
            w_off[i]   = r_off[i];
            w_cnt[i]   = r_cnt[i];
            w_phase[i] = r_phase[i];
            w_busy[i]  = r_busy[i];
            w_leds[i]  = 1'b0;

            if (w_hit[i]) begin
                w_mode[i]  = mode_t'(cfg_mode);
                w_on[i]    = cfg_on;
                w_off[i]   = cfg_off;
                w_cnt[i]   = '0;
                w_phase[i] = (cfg_mode == MODE_PULSE);
                w_busy[i]  = (cfg_mode == MODE_PULSE);
            end
`ifdef BLINK_SYNC_EN
            else if (sync_i && r_mode[i] == MODE_BLINK) begin
                w_cnt[i]   = '0;
                w_phase[i] = 1'b0;
            end
`endif
            else if (w_tick) begin
                unique case (r_mode[i])
                    MODE_BLINK: begin
                        if (r_cnt[i] == f_last(r_phase[i] ? r_on[i]
                                                          : r_off[i])) begin
                            w_cnt[i]   = '0;
                            w_phase[i] = ~r_phase[i];
                        end else begin
                            w_cnt[i] = r_cnt[i] + 1'b1;
                        end
                    end
                    MODE_PULSE: begin
                        if (r_cnt[i] == f_last(r_on[i])) begin
                            w_mode[i]  = MODE_OFF;
                            w_cnt[i]   = '0;
                            w_phase[i] = 1'b0;
                            w_busy[i]  = 1'b0;
                        end else begin
                            w_cnt[i] = r_cnt[i] + 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end

            unique case (w_mode[i])
                MODE_OFF:   w_leds[i] = 1'b0;
                MODE_ON:    w_leds[i] = 1'b1;
                MODE_BLINK: w_leds[i] = w_phase[i];
                MODE_PULSE: w_leds[i] = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre   <= '0;
            r_phase <= '0;
            r_leds  <= '0;
            r_busy  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_mode[i] <= MODE_BLINK;
                r_on[i]   <= TW'(ON_DEFAULT);
                r_off[i]  <= TW'(OFF_DEFAULT);
                r_cnt[i]  <= '0;
            end
        end else begin
            r_pre   <= w_pre;
            r_phase <= w_phase;
            r_leds  <= w_leds;
            r_busy  <= w_busy;
            for (int i = 0; i < CHANNELS; i++) begin
                r_mode[i] <= w_mode[i];
                r_on[i]   <= w_on[i];
                r_off[i]  <= w_off[i];
                r_cnt[i]  <= w_cnt[i];
            end
        end
    end

    assign leds       = r_leds;
    assign pulse_busy = r_busy;

endmodule

// File: tb/tb_blink_multi.sv
// Directed bench for blink_multi at TICK_DIV = 10.
// Define BLINK_SYNC_EN to also exercise sync_i.
module tb_blink_multi;

    localparam logic [1:0] M_OFF   = 2'b00;
    localparam logic [1:0] M_ON    = 2'b01;
    localparam logic [1:0] M_BLINK = 2'b10;
    localparam logic [1:0] M_PULSE = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [4:0]  cfg_ch;
    logic [1:0]  cfg_mode;
    logic [11:0] cfg_on;
    logic [11:0] cfg_off;
    logic [7:0]  leds;
    logic [7:0]  pulse_busy;
`ifdef BLINK_SYNC_EN
    logic        sync_i;
`endif

    int n_tests;
    int n_fail;
    int cyc_cnt;

    blink_multi #(
        .CLK_FREQ    (1000),
        .TICK_HZ     (100),
        .CHANNELS    (8),
        .TW          (12),
        .ON_DEFAULT  (2000),
        .OFF_DEFAULT (500)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_on     (cfg_on),
        .cfg_off    (cfg_off),
`ifdef BLINK_SYNC_EN
        .sync_i     (sync_i),
`endif
        .leds       (leds),
        .pulse_busy (pulse_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc_cnt++;
        end
        #1;
    endtask

    task automatic go_to(input int t);
        while (cyc_cnt < t) cyc(1);
    endtask

    task automatic wr(input logic [4:0] ch, input logic [1:0] m,
                      input logic [11:0] on, input logic [11:0] off);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_mode = m;
        cfg_on   = on;
        cfg_off  = off;
        cyc(1);
        cfg_we   = 1'b0;
    endtask

    task automatic release_rst;
        @(negedge clk);
        rst_n   = 1'b1;
        cyc_cnt = 0;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        cyc_cnt  = 0;
        rst_n    = 1'b0;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_mode = '0;
        cfg_on   = '0;
        cfg_off  = '0;
`ifdef BLINK_SYNC_EN
        sync_i   = 1'b0;
`endif
        cyc(3);
        chk("rst_leds", leds, 8'h00);
        chk("rst_busy", pulse_busy, 8'h00);

        // Default blink: dark 5000 cycles, lit 20000, dark again.
        release_rst();
        cyc(1);
        chk("def_c1", leds, 8'h00);
        go_to(4999);
        chk("def_c4999", leds, 8'h00);
        go_to(5000);
        chk("def_c5000", leds, 8'hFF);
        go_to(24999);
        chk("def_c24999", leds, 8'hFF);
        go_to(25000);
        chk("def_c25000", leds, 8'h00);
        chk("def_busy", pulse_busy, 8'h00);

        // ch2 BLINK on=3 off=2, applied at 25001.
        wr(5'd2, M_BLINK, 12'd3, 12'd2);
        go_to(25019);
        chk("blk_c19", leds, 8'h00);
        go_to(25020);
        chk("blk_c20", leds, 8'h04);
        go_to(25049);
        chk("blk_c49", leds, 8'h04);
        go_to(25050);
        chk("blk_c50", leds, 8'h00);
        go_to(25069);
        chk("blk_c69", leds, 8'h00);
        go_to(25070);
        chk("blk_c70", leds, 8'h04);

        // ch5 PULSE on=4, applied at 25071; ticks 80,90,100,110.
        wr(5'd5, M_PULSE, 12'd4, 12'd0);
        chk("pul_led_on", leds[5], 1'b1);
        chk("pul_busy_on", pulse_busy, 8'h20);
        go_to(25109);
        chk("pul_led_c109", leds[5], 1'b1);
        chk("pul_busy_c109", pulse_busy[5], 1'b1);
        go_to(25110);
        chk("pul_led_end", leds[5], 1'b0);
        chk("pul_busy_end", pulse_busy[5], 1'b0);

        // Re-trigger after two ticks extends to 4 ticks from re-write.
        wr(5'd5, M_PULSE, 12'd4, 12'd0);
        go_to(25130);
        wr(5'd5, M_PULSE, 12'd4, 12'd0);
        go_to(25150);
        chk("retrig_c150", leds[5], 1'b1);
        go_to(25169);
        chk("retrig_c169", pulse_busy[5], 1'b1);
        go_to(25170);
        chk("retrig_end_led", leds[5], 1'b0);
        chk("retrig_end_busy", pulse_busy[5], 1'b0);

        // Out-of-range channel must change nothing.
        wr(5'd9, M_ON, 12'd1, 12'd1);
        chk("oor_leds", leds, 8'h04);
        chk("oor_busy", pulse_busy, 8'h00);

        // Back-to-back ON then OFF on ch0.
        wr(5'd0, M_ON, 12'd1, 12'd1);
        chk("ch0_on", leds, 8'h05);
        wr(5'd0, M_OFF, 12'd1, 12'd1);
        chk("ch0_off", leds, 8'h04);

        // Zero times on ch3, write lands on tick edge 25180.
        go_to(25179);
        wr(5'd3, M_BLINK, 12'd0, 12'd0);
        chk("z_c180", leds[3], 1'b0);
        go_to(25189);
        chk("z_c189", leds[3], 1'b0);
        go_to(25190);
        chk("z_c190", leds[3], 1'b1);
        go_to(25199);
        chk("z_c199", leds[3], 1'b1);
        go_to(25200);
        chk("z_c200", leds[3], 1'b0);

        // Async reset in the middle of a pulse on ch6.
        wr(5'd6, M_PULSE, 12'd4, 12'd0);
        go_to(25205);
        chk("pre_ar_leds", leds, 8'h40);
        chk("pre_ar_busy", pulse_busy, 8'h40);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_leds", leds, 8'h00);
        chk("ar_busy", pulse_busy, 8'h00);
        cyc(2);
        release_rst();
        cyc(10);
        chk("post_ar_leds", leds, 8'h00);
        chk("post_ar_busy", pulse_busy, 8'h00);

`ifdef BLINK_SYNC_EN
        // Fresh reset so the prescaler phase is known again.
        rst_n = 1'b0;
        cyc(2);
        release_rst();
        wr(5'd0, M_BLINK, 12'd2, 12'd2);
        go_to(14);
        wr(5'd1, M_BLINK, 12'd2, 12'd2);
        go_to(25);
        chk("stagger", leds[1:0], 2'b01);
        go_to(32);
        sync_i = 1'b1;
        cyc(1);
        sync_i = 1'b0;
        chk("sync_c33", leds[1:0], 2'b00);
        go_to(52);
        chk("sync_c52", leds[1:0], 2'b00);
        go_to(53);
        chk("sync_c53", leds[1:0], 2'b11);
        go_to(72);
        chk("sync_c72", leds[1:0], 2'b11);
        go_to(73);
        chk("sync_c73", leds[1:0], 2'b00);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
